// File: rtl/vga_timing_gen_if.sv
// VGA timing bundle: pixel/line counters, active-low syncs, visible flag.
interface vga_timing_gen_if;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [9:0] hpos;
  logic [9:0] vpos;

  modport master (
    output hsync,
    output vsync,
    output display_on,
    output hpos,
    output vpos
  );

  modport slave (
    input hsync,
    input vsync,
    input display_on,
    input hpos,
    input vpos
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running 640x480@60 VGA timing generator.
// Counters and syncs are registered; display_on is decoded from the counters.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_BOTTOM  = 10,
  parameter int V_SYNC    = 2,
  parameter int V_TOP     = 33
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT
                         + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM
                         + V_SYNC + V_TOP;

  localparam logic [9:0] H_MAX =
    10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX =
    10'(V_TOTAL - 1);
  localparam logic [9:0] H_SS =
    10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SE =
    10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SS =
    10'(V_DISPLAY + V_BOTTOM);
  localparam logic [9:0] V_SE =
    10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
  localparam logic [9:0] H_VIS =
    10'(H_DISPLAY);
  localparam logic [9:0] V_VIS =
    10'(V_DISPLAY);

  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       hmaxxed;
  logic       vmaxxed;
  logic       h_zone;
  logic       v_zone;

  assign hmaxxed = (hpos == H_MAX);
  assign vmaxxed = (vpos == V_MAX);
  assign h_zone  = (hpos >= H_SS) && (hpos <= H_SE);
  assign v_zone  = (vpos >= V_SS) && (vpos <= V_SE);

  // Syncs follow the pre-edge counters, so they lag hpos/vpos by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos  <= '0;
      vpos  <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      hsync <= ~h_zone;
      vsync <= ~v_zone;
      if (hmaxxed) begin
        hpos <= '0;
        vpos <= vmaxxed ? '0 : vpos + 10'd1;
      end else begin
        hpos <= hpos + 10'd1;
      end
    end
  end

  assign vga.hpos       = hpos;
  assign vga.vpos       = vpos;
  assign vga.hsync      = hsync;
  assign vga.vsync      = vsync;
  assign vga.display_on = (hpos < H_VIS) && (vpos < V_VIS);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: full-size and scaled-down generators vs a time-index model.
module tb_vga_timing_gen;

  localparam int NCYC = 60000;
  localparam int BFR  = 32 * 19;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
  } obs_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  bit   done = 1'b0;
  int   checks = 0;
  int   failures = 0;
  obs_t qa[$];
  obs_t qb[$];

  vga_timing_gen_if va ();
  vga_timing_gen_if vb ();

  vga_timing_gen dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (va)
  );

  vga_timing_gen #(
    .H_DISPLAY (20),
    .H_FRONT   (3),
    .H_SYNC    (5),
    .H_BACK    (4),
    .V_DISPLAY (12),
    .V_BOTTOM  (2),
    .V_SYNC    (2),
    .V_TOP     (3)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (vb)
  );

  always #20 clk = ~clk;

  // t = clocks since the last reset edge; position is plain div/mod of t.
  function automatic obs_t model(
    input int t,
    input int hd, input int hf, input int hw, input int hb,
    input int vd, input int vf, input int vw, input int vt
  );
    obs_t e;
    int ht, vtot, ph, pv;
    ht   = hd + hf + hw + hb;
    vtot = vd + vf + vw + vt;
    e.h  = 10'(t % ht);
    e.v  = 10'((t / ht) % vtot);
    e.de = ((t % ht) < hd) && (((t / ht) % vtot) < vd);
    if (t == 0) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
    end else begin
      ph   = (t - 1) % ht;
      pv   = ((t - 1) / ht) % vtot;
      e.hs = !(ph >= hd + hf && ph < hd + hf + hw);
      e.vs = !(pv >= vd + vf && pv < vd + vf + vw);
    end
    return e;
  endfunction

  task automatic cmp_obs(input string name,
                         input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t act h=%0d v=%0d hs=%b vs=%b de=%b exp h=%0d v=%0d hs=%b vs=%b de=%b",
               name, $time, act.h, act.v, act.hs, act.vs, act.de,
               exp.h, exp.v, exp.hs, exp.vs, exp.de);
    end
  endtask

  task automatic cmp_int(input string name,
                         input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s @%0t act=%0d exp=%0d",
               name, $time, act, exp);
    end
  endtask

  initial begin : stim
    int  ta;
    int  tb_t;
    bit  ra;
    bit  rb;
    bit  bdir;
    ta   = 0;
    tb_t = 0;
    bdir = 1'b0;
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      ra = (i < 3) || (i >= 2500 && i < 2503)
        || (i > 5000 && $urandom_range(0, 3999) == 0);
      rb = (i < 3) || (i > 3000 && $urandom_range(0, 1499) == 0);
      // B reset for one clock while showing (10,7) in its second frame
      if (!bdir && tb_t == BFR + 7 * 32 + 10) begin
        rb   = 1'b1;
        bdir = 1'b1;
      end
      rst_a = ra;
      rst_b = rb;
      ta   = ra ? 0 : ta + 1;
      tb_t = rb ? 0 : tb_t + 1;
      qa.push_back(model(ta, 640, 16, 96, 48, 480, 10, 2, 33));
      qb.push_back(model(tb_t, 20, 3, 5, 4, 12, 2, 2, 3));
    end
    @(posedge clk);
    #5;
    done = 1'b1;
  end

  initial begin : mon
    obs_t act;
    int   hl_cnt;
    bit   hl_ok;
    int   vl_cnt;
    bit   vl_ok;
    logic vs_prev;
    hl_cnt  = 0;
    hl_ok   = 1'b0;
    vl_cnt  = 0;
    vl_ok   = 1'b0;
    vs_prev = 1'b1;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() == 0 || qb.size() == 0) begin
        if (done) break;
        checks++;
        failures++;
        $display("FAIL queue_empty @%0t act=empty exp=entry", $time);
        continue;
      end
      act = {va.hpos, va.vpos, va.hsync, va.vsync, va.display_on};
      cmp_obs("full", act, qa.pop_front());
      act = {vb.hpos, vb.vpos, vb.hsync, vb.vsync, vb.display_on};
      cmp_obs("small", act, qb.pop_front());

      if (rst_a) begin
        hl_cnt = 0;
        hl_ok  = 1'b1;
      end else begin
        if (va.hpos == 10'd0) begin
          if (hl_ok) cmp_int("hsync_low_per_line", hl_cnt, 96);
          hl_ok  = 1'b1;
          hl_cnt = 0;
        end
        if (!va.hsync) hl_cnt++;
      end

      if (rst_b) begin
        vl_ok   = 1'b0;
        vl_cnt  = 0;
        vs_prev = 1'b1;
      end else begin
        if (vs_prev && !vb.vsync) begin
          cmp_int("vsync_fall_h", int'(vb.hpos), 1);
          cmp_int("vsync_fall_v", int'(vb.vpos), 14);
          vl_ok  = 1'b1;
          vl_cnt = 0;
        end
        if (!vb.vsync) vl_cnt++;
        if (!vs_prev && vb.vsync && vl_ok) begin
          cmp_int("vsync_low_len", vl_cnt, 64);
          cmp_int("vsync_rise_v", int'(vb.vpos), 16);
          vl_ok = 1'b0;
        end
        vs_prev = vb.vsync;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
